dphy_lane_src_mux: RTL and testbench

- Registered N-source, W-bit data-lane multiplexer; parametrised successor of the combinational 2:1 lane mux.
- Sits ahead of the HS serializer and selects which upstream byte source (HS payload, test pattern, calibration, loopback) drives the lane.
- Source switching is burst-aware: a select change is applied only between bursts, with a one-cycle guard gap and a req/ack-style acknowledge, so a packet is never split across sources.

---
 rtl/dphy_lane_src_mux_if.sv | 33 +++
 rtl/dphy_lane_src_mux.sv | 159 +++++++++++++++
 tb/tb_dphy_lane_src_mux.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dphy_lane_src_mux_if.sv
// rtl/dphy_lane_src_mux_if.sv - source/lane bus bundle for the lane source mux
//
// Signals:
//   in_data   N*W  source data; source k occupies bits [k*W +: W]
//   in_valid  N    per-source beat valid
//   in_last   N    per-source last beat of burst, qualified by in_valid
//   out_data  W    registered lane data toward the serializer
//   out_valid 1    registered lane valid
//   out_last  1    registered lane last
// Modports:
//   master  upstream side: drives sources, observes the lane
//   slave   the mux: samples sources, drives the lane
interface dphy_lane_src_mux_if #(
    parameter int W = 8,
    parameter int N = 4
);
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_last;

    modport master (
        output in_data, in_valid, in_last,
        input  out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last,
        output out_data, out_valid, out_last
    );
endinterface

// File: rtl/dphy_lane_src_mux.sv
// rtl/dphy_lane_src_mux.sv - burst-aware registered N:1 lane source multiplexer
//
// Ports:
//   clk           lane byte clock, rising edge
//   rst_n         asynchronous active-low reset
//   lane          source inputs and registered lane outputs (slave modport)
//   sel_req_en_i  one-cycle strobe requesting a switch to sel_req_i
//   sel_req_i     requested source index (ignored when >= N)
//   sel_ack_o     one-cycle pulse when the pending request is applied
//   cur_sel_o     currently selected source
//   busy_o        high while a burst is in progress
//   drop_o        one-cycle pulse when a selected-source beat is discarded
module dphy_lane_src_mux #(
    parameter int W        = 8,
    parameter int N        = 4,
    parameter int INIT_SEL = 0,
    localparam int SW      = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dphy_lane_src_mux_if.slave    lane,
    input  logic                  sel_req_en_i,
    input  logic [SW-1:0]         sel_req_i,
    output logic                  sel_ack_o,
    output logic [SW-1:0]         cur_sel_o,
    output logic                  busy_o,
    output logic                  drop_o
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PASS   = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] cur_sel_q, cur_sel_d;
    logic [SW-1:0] pending_sel_q, pending_sel_d;
    logic          pending_q, pending_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          sel_ack_q, sel_ack_d;
    logic          drop_q, drop_d;

    logic          sel_valid;
    logic          sel_last;
    logic [W-1:0]  sel_data;
    logic          req_ok;
    logic          same_src;

    // Selected-source view; a compare loop keeps indexing in range for any N.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < N; k++) begin
            if (cur_sel_q == SW'(k)) begin
                sel_valid = lane.in_valid[k];
                sel_last  = lane.in_last[k];
                sel_data  = lane.in_data[k*W +: W];
            end
        end
    end

    assign req_ok   = sel_req_en_i && (int'(sel_req_i) < N);
    assign same_src = (pending_sel_q == cur_sel_q);

    always_comb begin
        state_d       = state_q;
        cur_sel_d     = cur_sel_q;
        pending_sel_d = pending_sel_q;
        pending_d     = pending_q;
        out_data_d    = out_data_q;
        out_valid_d   = 1'b0;
        out_last_d    = 1'b0;
        sel_ack_d     = 1'b0;
        drop_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    // Switch wins over a colliding beat; the beat is lost.
                    cur_sel_d = pending_sel_q;
                    sel_ack_d = 1'b1;
                    pending_d = 1'b0;
                    drop_d    = sel_valid;
                    state_d   = same_src ? ST_IDLE : ST_SWITCH;
                end else if (sel_valid) begin
                    out_data_d  = sel_data;
                    out_valid_d = 1'b1;
                    out_last_d  = sel_last;
                    state_d     = sel_last ? ST_IDLE : ST_PASS;
                end
            end
            ST_PASS: begin
                if (sel_valid) begin
                    out_data_d  = sel_data;
                    out_valid_d = 1'b1;
                    out_last_d  = sel_last;
                    if (sel_last) begin
                        if (pending_q) begin
                            // Apply on the closing edge so the ack lines up
                            // with the last beat on the lane.
                            cur_sel_d = pending_sel_q;
                            sel_ack_d = 1'b1;
                            pending_d = 1'b0;
                            state_d   = same_src ? ST_IDLE : ST_SWITCH;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_SWITCH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Capture after the apply so a request arriving on the apply cycle
        // survives as the next pending request.
        if (req_ok) begin
            pending_d     = 1'b1;
            pending_sel_d = sel_req_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cur_sel_q     <= SW'(INIT_SEL);
            pending_sel_q <= '0;
            pending_q     <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            sel_ack_q     <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_sel_q     <= cur_sel_d;
            pending_sel_q <= pending_sel_d;
            pending_q     <= pending_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            sel_ack_q     <= sel_ack_d;
            drop_q        <= drop_d;
        end
    end

    assign lane.out_data  = out_data_q;
    assign lane.out_valid = out_valid_q;
    assign lane.out_last  = out_last_q;
    assign sel_ack_o      = sel_ack_q;
    assign cur_sel_o      = cur_sel_q;
    assign busy_o         = (state_q == ST_PASS);
    assign drop_o         = drop_q;
endmodule

// File: tb/tb_dphy_lane_src_mux.sv
// tb/tb_dphy_lane_src_mux.sv - self-checking bench for dphy_lane_src_mux
module tb_dphy_lane_src_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // A: W=8 N=4 INIT_SEL=2 (model-checked)
    dphy_lane_src_mux_if #(.W(8), .N(4)) ifa ();
    logic a_en; logic [1:0] a_req; logic a_ack; logic [1:0] a_cur; logic a_busy, a_drop;
    dphy_lane_src_mux #(.W(8), .N(4), .INIT_SEL(2)) u_a (
        .clk(clk), .rst_n(rst_n), .lane(ifa), .sel_req_en_i(a_en), .sel_req_i(a_req),
        .sel_ack_o(a_ack), .cur_sel_o(a_cur), .busy_o(a_busy), .drop_o(a_drop));

    // B: W=2 N=2
    dphy_lane_src_mux_if #(.W(2), .N(2)) ifb ();
    logic b_en; logic [0:0] b_req; logic b_ack; logic [0:0] b_cur; logic b_busy, b_drop;
    dphy_lane_src_mux #(.W(2), .N(2), .INIT_SEL(0)) u_b (
        .clk(clk), .rst_n(rst_n), .lane(ifb), .sel_req_en_i(b_en), .sel_req_i(b_req),
        .sel_ack_o(b_ack), .cur_sel_o(b_cur), .busy_o(b_busy), .drop_o(b_drop));

    // C: W=32 N=16
    dphy_lane_src_mux_if #(.W(32), .N(16)) ifc ();
    logic c_en; logic [3:0] c_req; logic c_ack; logic [3:0] c_cur; logic c_busy, c_drop;
    dphy_lane_src_mux #(.W(32), .N(16), .INIT_SEL(0)) u_c (
        .clk(clk), .rst_n(rst_n), .lane(ifc), .sel_req_en_i(c_en), .sel_req_i(c_req),
        .sel_ack_o(c_ack), .cur_sel_o(c_cur), .busy_o(c_busy), .drop_o(c_drop));

    // D: W=8 N=5, so out-of-range indices are representable
    dphy_lane_src_mux_if #(.W(8), .N(5)) ifd ();
    logic d_en; logic [2:0] d_req; logic d_ack; logic [2:0] d_cur; logic d_busy, d_drop;
    dphy_lane_src_mux #(.W(8), .N(5), .INIT_SEL(0)) u_d (
        .clk(clk), .rst_n(rst_n), .lane(ifd), .sel_req_en_i(d_en), .sel_req_i(d_req),
        .sel_ack_o(d_ack), .cur_sel_o(d_cur), .busy_o(d_busy), .drop_o(d_drop));

    // Reference model for A, phrased as "inside a burst" / "owes a guard cycle".
    int         m_cur;
    bit         m_pend;
    int         m_psel;
    bit         m_burst;
    bit         m_guard;
    logic [7:0] e_data;
    bit         e_valid, e_last, e_ack, e_drop;

    task automatic model_reset_a();
        m_cur = 2; m_pend = 0; m_psel = 0; m_burst = 0; m_guard = 0;
        e_data = 8'h00; e_valid = 0; e_last = 0; e_ack = 0; e_drop = 0;
    endtask

    task automatic model_apply();
        e_ack   = 1;
        m_guard = (m_psel != m_cur);
        m_cur   = m_psel;
        m_pend  = 0;
    endtask

    task automatic model_step();
        bit cv, cl;
        logic [7:0] cd;
        cv = ifa.in_valid[m_cur];
        cl = ifa.in_last[m_cur];
        cd = ifa.in_data[m_cur*8 +: 8];
        e_ack = 0; e_drop = 0; e_valid = 0; e_last = 0;
        if (m_guard) begin
            m_guard = 0;
        end else if (!m_burst && m_pend) begin
            e_drop = cv;
            model_apply();
        end else if (cv) begin
            e_valid = 1; e_data = cd; e_last = cl;
            if (!m_burst) begin
                m_burst = !cl;
            end else if (cl) begin
                m_burst = 0;
                if (m_pend) model_apply();
            end
        end
        if (a_en) begin
            m_pend = 1;
            m_psel = a_req;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance A and the model one cycle and compare every output.
    task automatic step_a(input string tag);
        model_step();
        tick();
        n_checks += 7;
        if (ifa.out_valid !== e_valid) begin n_fail++; $display("FAIL %s out_valid: got %b want %b", tag, ifa.out_valid, e_valid); end
        if (ifa.out_data !== e_data) begin n_fail++; $display("FAIL %s out_data: got %h want %h", tag, ifa.out_data, e_data); end
        if (ifa.out_last !== e_last) begin n_fail++; $display("FAIL %s out_last: got %b want %b", tag, ifa.out_last, e_last); end
        if (a_ack !== e_ack) begin n_fail++; $display("FAIL %s sel_ack: got %b want %b", tag, a_ack, e_ack); end
        if (a_drop !== e_drop) begin n_fail++; $display("FAIL %s drop: got %b want %b", tag, a_drop, e_drop); end
        if (a_busy !== m_burst) begin n_fail++; $display("FAIL %s busy: got %b want %b", tag, a_busy, m_burst); end
        if (a_cur !== 2'(m_cur)) begin n_fail++; $display("FAIL %s cur_sel: got %0d want %0d", tag, a_cur, m_cur); end
    endtask

    task automatic test_reset();
        ifa.in_valid = 4'b0100; ifa.in_last = 4'b0100; ifa.in_data = 32'h00A5_0000;
        repeat (2) tick();
        n_checks += 4;
        if (ifa.out_valid !== 1'b0 || ifa.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_vl: got %b%b want 00", ifa.out_valid, ifa.out_last); end
        if (ifa.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data: got %h want 00", ifa.out_data); end
        if (a_cur !== 2'd2) begin n_fail++; $display("FAIL rst_cur_sel: got %0d want 2", a_cur); end
        if ({a_ack, a_drop, a_busy} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {a_ack, a_drop, a_busy}); end
        rst_n = 1'b1;
        model_reset_a();
        step_a("reset_first");
        n_checks++;
        if (ifa.out_data !== 8'hA5 || ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL reset_first_beat: got %b/%h want 1/a5", ifa.out_valid, ifa.out_data); end
        ifa.in_valid = '0; ifa.in_last = '0;
        step_a("reset_idle");
    endtask

    task automatic test_burst_hold();
        a_en = 1; a_req = 2'd0; step_a("bh_req0");
        a_en = 0; step_a("bh_apply0");
        step_a("bh_guard0");
        ifa.in_valid = 4'b0001; ifa.in_last = 4'b0000; ifa.in_data = 32'h0000_0010; step_a("bh_b0");
        ifa.in_data = 32'h0000_0011; a_en = 1; a_req = 2'd3; step_a("bh_b1");
        a_en = 0; ifa.in_data = 32'h0000_0012; ifa.in_last = 4'b0001; step_a("bh_b2");
        n_checks++;
        if (a_ack !== 1'b1 || ifa.out_last !== 1'b1 || ifa.out_data !== 8'h12) begin n_fail++; $display("FAIL bh_ack_with_last: got ack=%b last=%b data=%h want 1 1 12", a_ack, ifa.out_last, ifa.out_data); end
        ifa.in_valid = 4'b1000; ifa.in_last = 4'b1000; ifa.in_data = 32'hF000_0000; step_a("bh_gap");
        n_checks++;
        if (ifa.out_valid !== 1'b0 || a_cur !== 2'd3) begin n_fail++; $display("FAIL bh_gap: got valid=%b cur=%0d want 0 3", ifa.out_valid, a_cur); end
        step_a("bh_f0");
        n_checks++;
        if (ifa.out_valid !== 1'b1 || ifa.out_data !== 8'hF0) begin n_fail++; $display("FAIL bh_f0: got %b/%h want 1/f0", ifa.out_valid, ifa.out_data); end
        ifa.in_valid = '0; ifa.in_last = '0; step_a("bh_end");
    endtask

    task automatic test_collision();
        a_en = 1; a_req = 2'd1; step_a("col_req");
        a_en = 0; ifa.in_valid = 4'b1000; ifa.in_last = 4'b1000; ifa.in_data = 32'h5500_0000; step_a("col_hit");
        n_checks++;
        if (a_drop !== 1'b1 || ifa.out_valid !== 1'b0 || a_cur !== 2'd1) begin n_fail++; $display("FAIL col_drop: got drop=%b valid=%b cur=%0d want 1 0 1", a_drop, ifa.out_valid, a_cur); end
        ifa.in_valid = '0; ifa.in_last = '0; step_a("col_guard");
        n_checks++;
        if (ifa.out_data === 8'h55) begin n_fail++; $display("FAIL col_leak: got %h want not 55", ifa.out_data); end
        step_a("col_idle");
    endtask

    task automatic test_overwrite();
        int acks = 0;
        ifa.in_valid = 4'b0010; ifa.in_last = 4'b0000; ifa.in_data = 32'h0000_2100;
        a_en = 1; a_req = 2'd1; step_a("ow_b0"); acks += int'(a_ack);
        ifa.in_data = 32'h0000_2200; a_req = 2'd2; step_a("ow_b1"); acks += int'(a_ack);
        a_en = 0; ifa.in_data = 32'h0000_2300; ifa.in_last = 4'b0010; step_a("ow_b2"); acks += int'(a_ack);
        ifa.in_valid = '0; ifa.in_last = '0;
        repeat (3) begin step_a("ow_tail"); acks += int'(a_ack); end
        n_checks++;
        if (acks !== 1 || a_cur !== 2'd2) begin n_fail++; $display("FAIL ow_single_ack: got acks=%0d cur=%0d want 1 2", acks, a_cur); end
    endtask

    task automatic test_invalid_req();
        int acks = 0;
        d_en = 1; d_req = 3'd5; tick(); acks += int'(d_ack);
        d_req = 3'd7; tick(); acks += int'(d_ack);
        d_en = 0;
        repeat (3) begin tick(); acks += int'(d_ack); end
        n_checks++;
        if (acks !== 0 || d_cur !== 3'd0) begin n_fail++; $display("FAIL inv_ignored: got acks=%0d cur=%0d want 0 0", acks, d_cur); end
        d_en = 1; d_req = 3'd4; tick();
        d_en = 0; tick();
        n_checks++;
        if (d_ack !== 1'b1 || d_cur !== 3'd4) begin n_fail++; $display("FAIL inv_valid_ok: got ack=%b cur=%0d want 1 4", d_ack, d_cur); end
    endtask

    task automatic test_reset_mid_burst();
        a_en = 1; a_req = 2'd1; step_a("mb_req");
        a_en = 0; step_a("mb_apply"); step_a("mb_guard");
        ifa.in_valid = 4'b0110; ifa.in_last = 4'b0000; ifa.in_data = 32'h0031_3100; step_a("mb_b1");
        ifa.in_data = 32'h0032_3200;
        #2; rst_n = 1'b0; #1;
        n_checks++;
        if (ifa.out_valid !== 1'b0 || a_cur !== 2'd2 || a_busy !== 1'b0) begin n_fail++; $display("FAIL mb_async: got valid=%b cur=%0d busy=%b want 0 2 0", ifa.out_valid, a_cur, a_busy); end
        tick();
        rst_n = 1'b1;
        model_reset_a();
        ifa.in_data = 32'h0033_3300; step_a("mb_b3");
        n_checks++;
        if (a_busy !== 1'b1 || ifa.out_data !== 8'h33) begin n_fail++; $display("FAIL mb_fresh_pass: got busy=%b data=%h want 1 33", a_busy, ifa.out_data); end
        ifa.in_data = 32'h0034_3400; ifa.in_last = 4'b0110; step_a("mb_b4");
        n_checks++;
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL mb_end: got busy=%b want 0", a_busy); end
        ifa.in_valid = '0; ifa.in_last = '0; step_a("mb_idle");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ifa.in_valid = 4'($urandom);
            ifa.in_last  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            ifa.in_data  = $urandom;
            a_en  = ($urandom_range(0, 9) == 0);
            a_req = 2'($urandom);
            step_a("rand");
        end
        a_en = 0; ifa.in_valid = '0; ifa.in_last = '0;
        repeat (3) step_a("rand_drain");
    endtask

    task automatic test_sweep_n2();
        logic [1:0] p0, p1, want;
        for (int k = 0; k < 2; k++) begin
            ifb.in_valid = '0; ifb.in_last = '0;
            b_en = 1; b_req = 1'(k); tick();
            b_en = 0; tick();
            n_checks++;
            if (b_cur !== 1'(k)) begin n_fail++; $display("FAIL n2_sel%0d: got %0d want %0d", k, b_cur, k); end
            tick();
            for (int p = 0; p < 2; p++) begin
                p0 = (p == 0) ? 2'b10 : 2'b01;
                p1 = ~p0;
                want = (k == 0) ? p0 : p1;
                ifb.in_valid = 2'b11; ifb.in_last = 2'b11; ifb.in_data = {p1, p0};
                tick();
                n_checks++;
                if (ifb.out_valid !== 1'b1 || ifb.out_data !== want) begin n_fail++; $display("FAIL n2_route%0d_%0d: got %b/%b want 1/%b", k, p, ifb.out_valid, ifb.out_data, want); end
            end
        end
        ifb.in_valid = '0; ifb.in_last = '0; tick();
    endtask

    task automatic test_sweep_n16();
        logic [31:0] src [16];
        for (int k = 0; k < 16; k++) begin
            ifc.in_valid = '0; ifc.in_last = '0;
            c_en = 1; c_req = 4'(k); tick();
            c_en = 0; tick();
            n_checks++;
            if (c_ack !== 1'b1 || c_cur !== 4'(k)) begin n_fail++; $display("FAIL n16_sel%0d: got ack=%b cur=%0d want 1 %0d", k, c_ack, c_cur, k); end
            tick();
            for (int c = 0; c < 3; c++) begin
                for (int j = 0; j < 16; j++) begin
                    src[j] = $urandom;
                    ifc.in_data[j*32 +: 32] = src[j];
                end
                ifc.in_valid = '1; ifc.in_last = '1;
                tick();
                n_checks++;
                if (ifc.out_valid !== 1'b1 || ifc.out_data !== src[k]) begin n_fail++; $display("FAIL n16_b2b%0d_%0d: got %b/%h want 1/%h", k, c, ifc.out_valid, ifc.out_data, src[k]); end
            end
        end
        ifc.in_valid = '0; ifc.in_last = '0; tick();
    endtask

    initial begin
        a_en = 0; a_req = '0; b_en = 0; b_req = '0; c_en = 0; c_req = '0; d_en = 0; d_req = '0;
        ifa.in_valid = '0; ifa.in_last = '0; ifa.in_data = '0;
        ifb.in_valid = '0; ifb.in_last = '0; ifb.in_data = '0;
        ifc.in_valid = '0; ifc.in_last = '0; ifc.in_data = '0;
        ifd.in_valid = '0; ifd.in_last = '0; ifd.in_data = '0;
        model_reset_a();
        test_reset();
        test_burst_hold();
        test_collision();
        test_overwrite();
        test_invalid_req();
        test_reset_mid_burst();
        test_random();
        test_sweep_n2();
        test_sweep_n16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
